// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch-operand stalls,
// taken-branch flush and data-memory wait freeze for the 5-stage core.
module hazard_ctrl #(
    parameter int DELAY_SLOT  = 1,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_addra,
    input  logic [4:0]       id_addrb,
    input  logic             id_usea,
    input  logic             id_useb,
    input  logic             id_branch,
    input  logic             id_taken,
    input  logic [4:0]       ex_regdest,
    input  logic             ex_writereg,
    input  logic             ex_load,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             hz_if_id_stall,
    output logic             hz_mem_stall,
    output logic             hz_pc_we,
    output logic             hz_if_flush,
    output logic             hz_timeout,
    output logic [CNT_W-1:0] hz_stall_count
);

    localparam int WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] WMAX = WW'(MEM_TIMEOUT);
    localparam bit FLUSH_EN = (DELAY_SLOT == 0);

    typedef enum logic [1:0] {RUN, LDBR, MEMWAIT} state_t;

    state_t           state_q, state_d;
    logic             ret_q, ret_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic             tmo_q, tmo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic dep_a, dep_b, dep, need1, need2, mem_pend;
    logic ifid, mstall, flush, stall_any;

    always_comb begin
        dep_a = id_usea & ex_writereg & (id_addra != 5'd0)
              & (id_addra == ex_regdest);
        dep_b = id_useb & ex_writereg & (id_addrb != 5'd0)
              & (id_addrb == ex_regdest);
        dep   = dep_a | dep_b;
        need2 = dep & ex_load & id_branch;
        need1 = dep & (ex_load | id_branch) & ~need2;
        mem_pend = mem_req & ~mem_ack;

        state_d = state_q;
        ret_d   = ret_q;
        wait_d  = wait_q;
        tmo_d   = tmo_q;
        ifid    = 1'b0;
        mstall  = 1'b0;
        flush   = 1'b0;

        unique case (state_q)
            RUN: begin
                if (mem_pend) begin
                    mstall  = 1'b1;
                    state_d = MEMWAIT;
                    ret_d   = 1'b0;
                    wait_d  = '0;
                end else if (need2) begin
                    ifid    = 1'b1;
                    state_d = LDBR;
                end else if (need1) begin
                    ifid = 1'b1;
                end else if (id_taken && FLUSH_EN) begin
                    flush = 1'b1;
                end
            end
            LDBR: begin
                // a memory freeze here must come back to finish the 2nd bubble
                if (mem_pend) begin
                    mstall  = 1'b1;
                    state_d = MEMWAIT;
                    ret_d   = 1'b1;
                    wait_d  = '0;
                end else begin
                    ifid    = 1'b1;
                    state_d = RUN;
                end
            end
            MEMWAIT: begin
                mstall = ~mem_ack;
                if (mem_ack) begin
                    state_d = ret_q ? LDBR : RUN;
                end else begin
                    if (wait_q != WMAX) wait_d = wait_q + WW'(1);
                    if (wait_q + WW'(1) == WMAX) tmo_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        stall_any = ifid | mstall;
        cnt_d = cnt_q;
        if (stall_any && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            ret_q   <= 1'b0;
            wait_q  <= '0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            wait_q  <= wait_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz_if_id_stall = ~reset & ifid;
    assign hz_mem_stall   = ~reset & mstall;
    assign hz_if_flush    = ~reset & flush;
    assign hz_pc_we       = ~reset & ~stall_any;
    assign hz_timeout     = tmo_q;
    assign hz_stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random
// traffic, checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int TMO = 15;
    localparam int CW  = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    id_addra, id_addrb, ex_regdest;
    logic          id_usea, id_useb, id_branch, id_taken;
    logic          ex_writereg, ex_load, mem_req, mem_ack;
    logic          hz_if_id_stall, hz_mem_stall, hz_pc_we;
    logic          hz_if_flush, hz_timeout;
    logic [CW-1:0] hz_stall_count;

    hazard_ctrl #(
        .DELAY_SLOT (0),
        .MEM_TIMEOUT(TMO),
        .CNT_W      (CW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .id_addra      (id_addra),
        .id_addrb      (id_addrb),
        .id_usea       (id_usea),
        .id_useb       (id_useb),
        .id_branch     (id_branch),
        .id_taken      (id_taken),
        .ex_regdest    (ex_regdest),
        .ex_writereg   (ex_writereg),
        .ex_load       (ex_load),
        .mem_req       (mem_req),
        .mem_ack       (mem_ack),
        .hz_if_id_stall(hz_if_id_stall),
        .hz_mem_stall  (hz_mem_stall),
        .hz_pc_we      (hz_pc_we),
        .hz_if_flush   (hz_if_flush),
        .hz_timeout    (hz_timeout),
        .hz_stall_count(hz_stall_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            tag;
        logic          ifid, mst, pcwe, fl, tmo;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad   = 0;

    // reference model: pending extra bubble, memory wait bookkeeping
    bit m_extra  = 0;
    bit m_wait   = 0;
    bit m_resume = 0;
    int m_waited = 0;
    int m_stalls = 0;
    bit m_tmo    = 0;

    task automatic clr();
        id_addra = 0; id_addrb = 0; ex_regdest = 0;
        id_usea = 0; id_useb = 0; id_branch = 0; id_taken = 0;
        ex_writereg = 0; ex_load = 0; mem_req = 0; mem_ack = 0;
    endtask

    task automatic tick(input int tag);
        exp_t e;
        bit   d;
        e.tag  = tag;
        e.tmo  = m_tmo;
        e.cnt  = CW'(m_stalls);
        e.ifid = 0;
        e.mst  = 0;
        e.fl   = 0;
        e.pcwe = 0;
        if (reset) begin
            m_extra = 0; m_wait = 0; m_resume = 0;
            m_waited = 0; m_stalls = 0; m_tmo = 0;
        end else begin
            d = (id_usea && ex_writereg && id_addra != 0
                 && id_addra == ex_regdest)
             || (id_useb && ex_writereg && id_addrb != 0
                 && id_addrb == ex_regdest);
            if (m_wait) begin
                e.mst = !mem_ack;
                if (mem_ack) begin
                    m_wait  = 0;
                    m_extra = m_resume;
                end else begin
                    m_waited++;
                    if (m_waited >= TMO) m_tmo = 1;
                end
            end else if (mem_req && !mem_ack) begin
                e.mst    = 1;
                m_wait   = 1;
                m_waited = 0;
                m_resume = m_extra;
                m_extra  = 0;
            end else if (m_extra) begin
                e.ifid  = 1;
                m_extra = 0;
            end else if (d && ex_load && id_branch) begin
                e.ifid  = 1;
                m_extra = 1;
            end else if (d && (ex_load || id_branch)) begin
                e.ifid = 1;
            end else if (id_taken) begin
                e.fl = 1;
            end
            e.pcwe = !(e.ifid || e.mst);
            if ((e.ifid || e.mst) && m_stalls < CMAX) m_stalls++;
        end
        sbq.push_back(e);
        @(posedge clock);
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                total++;
                if ({hz_if_id_stall, hz_mem_stall, hz_pc_we, hz_if_flush,
                     hz_timeout, hz_stall_count}
                    !== {e.ifid, e.mst, e.pcwe, e.fl, e.tmo, e.cnt}) begin
                    bad++;
                    $display("FAIL tag%0d t=%0t got ifid=%b mem=%b pcwe=%b fl=%b tmo=%b cnt=%0d want ifid=%b mem=%b pcwe=%b fl=%b tmo=%b cnt=%0d",
                             e.tag, $time, hz_if_id_stall, hz_mem_stall,
                             hz_pc_we, hz_if_flush, hz_timeout,
                             hz_stall_count, e.ifid, e.mst, e.pcwe, e.fl,
                             e.tmo, e.cnt);
                end
            end
        end
    end

    initial begin
        int mleft;
        clr();
        reset = 1;
        @(posedge clock);
        #1;
        // reset forces combinational outputs low even with activity
        mem_req = 1; id_taken = 1;
        tick(1); tick(1);
        reset = 0;
        clr();
        tick(1);
        // load-use
        ex_load = 1; ex_writereg = 1; ex_regdest = 8;
        id_usea = 1; id_addra = 8;
        tick(2);
        clr();
        tick(2); tick(2);
        // load then branch: two bubbles
        ex_load = 1; ex_writereg = 1; ex_regdest = 9;
        id_useb = 1; id_addrb = 9; id_branch = 1;
        tick(3);
        ex_load = 0; ex_writereg = 0;
        tick(3); tick(3);
        clr();
        tick(3);
        // alu then branch, then r0 never hazards
        ex_writereg = 1; ex_regdest = 3;
        id_branch = 1; id_usea = 1; id_addra = 3;
        tick(4);
        clr();
        tick(4);
        ex_writereg = 1; ex_load = 1; ex_regdest = 0;
        id_branch = 1; id_usea = 1; id_addra = 0;
        tick(4);
        clr();
        // memory wait of 4 cycles, then same-cycle ack
        mem_req = 1;
        repeat (4) tick(5);
        mem_ack = 1;
        tick(5);
        tick(5);
        clr();
        tick(5);
        // memory wait of 20 cycles: timeout is sticky
        mem_req = 1;
        repeat (20) tick(5);
        mem_ack = 1;
        tick(5);
        clr();
        repeat (3) tick(5);
        // flush, then flush masked by memory stall
        id_taken = 1;
        tick(6);
        mem_req = 1;
        tick(6);
        mem_ack = 1;
        tick(6);
        clr();
        tick(6);
        // second bubble interrupted by a memory wait
        ex_load = 1; ex_writereg = 1; ex_regdest = 5;
        id_usea = 1; id_addra = 5; id_branch = 1;
        tick(7);
        clr();
        mem_req = 1;
        repeat (3) tick(7);
        mem_ack = 1;
        tick(7);
        clr();
        tick(7); tick(7);
        // reset in the middle of a memory wait
        mem_req = 1;
        repeat (3) tick(7);
        reset = 1;
        tick(7);
        reset = 0;
        clr();
        tick(7); tick(7);
        // random traffic
        mleft = -1;
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 399) == 0);
            if (reset) mleft = -1;
            if (mleft < 0 && $urandom_range(0, 7) == 0)
                mleft = $urandom_range(0, 20);
            mem_req = (mleft >= 0);
            mem_ack = (mleft == 0);
            if (mleft >= 0) mleft--;
            id_addra    = 5'($urandom_range(0, 3));
            id_addrb    = 5'($urandom_range(0, 3));
            ex_regdest  = 5'($urandom_range(0, 3));
            id_usea     = 1'($urandom_range(0, 1));
            id_useb     = 1'($urandom_range(0, 1));
            ex_writereg = 1'($urandom_range(0, 1));
            ex_load     = ($urandom_range(0, 2) == 0);
            id_branch   = ($urandom_range(0, 2) == 0);
            id_taken    = ($urandom_range(0, 3) == 0);
            tick(8);
        end
        reset = 0;
        clr();
        repeat (3) tick(9);
        repeat (3) @(negedge clock);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
